// File: rtl/captcha_sequence_recorder.sv
// Producer side of the CAPTCHA result path: generates six distinct expected serials from an LFSR,
// presents each for a fixed dwell, then records six user selections with reject and undo.
module captcha_sequence_recorder #(
  parameter int unsigned MAX_ROUND         = 6,
  parameter int unsigned SERIAL_MAX        = 16,
  parameter int unsigned IMPOSSIBLE_SERIAL = 31,
  parameter int unsigned SHOW_CYCLES       = 100_000_000,
  parameter logic [7:0]  LFSR_SEED         = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       restart,
  input  logic       inp_valid,
  input  logic [4:0] inp_serial,
  input  logic       undo,
  output logic       inp_ready,
  output logic       inp_reject,
  output logic       show_valid,
  output logic [4:0] show_serial,
  output logic [2:0] input_count,
  output logic [4:0] first_act,
  output logic [4:0] second_act,
  output logic [4:0] third_act,
  output logic [4:0] fourth_act,
  output logic [4:0] fifth_act,
  output logic [4:0] sixth_act,
  output logic [4:0] first_inp,
  output logic [4:0] second_inp,
  output logic [4:0] third_inp,
  output logic [4:0] fourth_inp,
  output logic [4:0] fifth_inp,
  output logic [4:0] sixth_inp,
  output logic       is_second_part_completed
);

  localparam int unsigned DwellW    = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [DwellW-1:0] LastDwell = DwellW'(SHOW_CYCLES - 1);
  localparam logic [4:0] NoSerial  = 5'(IMPOSSIBLE_SERIAL);
  localparam logic [4:0] MaxSerial = 5'(SERIAL_MAX);
  localparam logic [2:0] LastSlot  = 3'(MAX_ROUND - 1);

  typedef enum logic [2:0] {StIdle, StGenerate, StShow, StCollect, StDone} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [7:0]        r_lfsr;
  logic [4:0]        r_act [MAX_ROUND];
  logic [4:0]        r_inp [MAX_ROUND];
  logic [2:0]        r_gen_idx;
  logic [2:0]        r_show_idx;
  logic [DwellW-1:0] r_dwell;
  logic [2:0]        r_count;
  logic              r_show_valid;
  logic [4:0]        r_show_serial;
  logic              r_reject;
  logic              r_completed;

  logic       w_lfsr_fb;
  logic [4:0] w_cand;
  logic       w_cand_dup;
  logic       w_cand_ok;
  logic       w_dwell_end;
  logic [2:0] w_show_next_idx;
  logic       w_transfer;
  logic       w_accept_inp;

  // Taps for x^8+x^6+x^5+x^4+1, shifting left.
  assign w_lfsr_fb       = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_cand          = r_lfsr[4:0];
  assign w_cand_ok       = (w_cand <= MaxSerial) && !w_cand_dup;
  assign w_dwell_end     = (r_dwell == LastDwell);
  assign w_show_next_idx = r_show_idx + 3'd1;
  assign inp_ready       = (r_state == StCollect) && (r_count < 3'(MAX_ROUND));
  assign w_transfer      = inp_valid && inp_ready && !undo;
  assign w_accept_inp    = w_transfer && (inp_serial <= MaxSerial);

  always_comb begin
    w_cand_dup = 1'b0;
    for (int i = 0; i < MAX_ROUND; i++) begin
      if ((3'(i) < r_gen_idx) && (r_act[i] == w_cand)) w_cand_dup = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:     if (start) w_state_next = StGenerate;
      StGenerate: if (w_cand_ok && (r_gen_idx == LastSlot)) w_state_next = StShow;
      StShow:     if (w_dwell_end && (r_show_idx == LastSlot)) w_state_next = StCollect;
      StCollect:  if (w_accept_inp && (r_count == LastSlot)) w_state_next = StDone;
      StDone:     if (restart) w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr        <= LFSR_SEED;
      r_gen_idx     <= 3'd0;
      r_show_idx    <= 3'd0;
      r_dwell       <= '0;
      r_count       <= 3'd0;
      r_show_valid  <= 1'b0;
      r_show_serial <= NoSerial;
      r_reject      <= 1'b0;
      r_completed   <= 1'b0;
      for (int i = 0; i < MAX_ROUND; i++) begin
        r_act[i] <= NoSerial;
        r_inp[i] <= NoSerial;
      end
    end else begin
      r_lfsr   <= {r_lfsr[6:0], w_lfsr_fb};
      r_reject <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_gen_idx <= 3'd0;
            for (int i = 0; i < MAX_ROUND; i++) begin
              r_act[i] <= NoSerial;
              r_inp[i] <= NoSerial;
            end
          end
        end
        StGenerate: begin
          if (w_cand_ok) begin
            r_act[r_gen_idx] <= w_cand;
            r_gen_idx        <= r_gen_idx + 3'd1;
            if (r_gen_idx == LastSlot) begin
              r_show_idx    <= 3'd0;
              r_dwell       <= '0;
              r_show_valid  <= 1'b1;
              r_show_serial <= r_act[0];
            end
          end
        end
        StShow: begin
          if (w_dwell_end) begin
            r_dwell <= '0;
            if (r_show_idx == LastSlot) begin
              r_show_valid  <= 1'b0;
              r_show_serial <= NoSerial;
            end else begin
              r_show_idx    <= w_show_next_idx;
              r_show_serial <= r_act[w_show_next_idx];
            end
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
        StCollect: begin
          // Undo wins over a same-cycle offer; the offer is dropped.
          if (undo) begin
            if (r_count != 3'd0) begin
              r_count                <= r_count - 3'd1;
              r_inp[r_count - 3'd1]  <= NoSerial;
            end
          end else if (w_transfer) begin
            if (w_accept_inp) begin
              r_inp[r_count] <= inp_serial;
              r_count        <= r_count + 3'd1;
              if (r_count == LastSlot) r_completed <= 1'b1;
            end else begin
              r_reject <= 1'b1;
            end
          end
        end
        StDone: begin
          if (restart) begin
            r_count     <= 3'd0;
            r_completed <= 1'b0;
            for (int i = 0; i < MAX_ROUND; i++) begin
              r_act[i] <= NoSerial;
              r_inp[i] <= NoSerial;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign inp_reject               = r_reject;
  assign show_valid               = r_show_valid;
  assign show_serial              = r_show_serial;
  assign input_count              = r_count;
  assign is_second_part_completed = r_completed;
  assign first_act                = r_act[0];
  assign second_act               = r_act[1];
  assign third_act                = r_act[2];
  assign fourth_act               = r_act[3];
  assign fifth_act                = r_act[4];
  assign sixth_act                = r_act[5];
  assign first_inp                = r_inp[0];
  assign second_inp               = r_inp[1];
  assign third_inp                = r_inp[2];
  assign fourth_inp               = r_inp[3];
  assign fifth_inp                = r_inp[4];
  assign sixth_inp                = r_inp[5];

endmodule

// File: tb/tb_captcha_sequence_recorder.sv
// Self-checking bench for captcha_sequence_recorder with a short dwell; expected sequences come
// from an LFSR sequence model and a queue model of the user's recorded selections.
module tb_captcha_sequence_recorder;

  localparam int ShowCycles = 4;

  logic       clock = 1'b0;
  logic       reset, start, restart, inp_valid, undo;
  logic [4:0] inp_serial;
  logic       inp_ready, inp_reject, show_valid, is_second_part_completed;
  logic [4:0] show_serial;
  logic [2:0] input_count;
  logic [4:0] first_act, second_act, third_act, fourth_act, fifth_act, sixth_act;
  logic [4:0] first_inp, second_inp, third_inp, fourth_inp, fifth_inp, sixth_inp;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [4:0] exp_act [6];
  int         exp_ncyc;
  logic [4:0] fill_vals [6];
  logic [4:0] act_w [6];
  logic [4:0] inp_w [6];
  logic [7:0] m_lfsr;

  captcha_sequence_recorder #(.SHOW_CYCLES(ShowCycles)) dut (
    .clock(clock), .reset(reset), .start(start), .restart(restart),
    .inp_valid(inp_valid), .inp_serial(inp_serial), .undo(undo),
    .inp_ready(inp_ready), .inp_reject(inp_reject), .show_valid(show_valid),
    .show_serial(show_serial), .input_count(input_count),
    .first_act(first_act), .second_act(second_act), .third_act(third_act),
    .fourth_act(fourth_act), .fifth_act(fifth_act), .sixth_act(sixth_act),
    .first_inp(first_inp), .second_inp(second_inp), .third_inp(third_inp),
    .fourth_inp(fourth_inp), .fifth_inp(fifth_inp), .sixth_inp(sixth_inp),
    .is_second_part_completed(is_second_part_completed)
  );

  always #5 clock = ~clock;

  assign act_w[0] = first_act;  assign act_w[1] = second_act; assign act_w[2] = third_act;
  assign act_w[3] = fourth_act; assign act_w[4] = fifth_act;  assign act_w[5] = sixth_act;
  assign inp_w[0] = first_inp;  assign inp_w[1] = second_inp; assign inp_w[2] = third_inp;
  assign inp_w[3] = fourth_inp; assign inp_w[4] = fifth_inp;  assign inp_w[5] = sixth_inp;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Free-running reference LFSR: one step per clock edge since reset.
  always @(posedge clock or posedge reset) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= lfsr_next(m_lfsr);
  end

  // First six distinct in-range candidates starting from the given LFSR value.
  task automatic model_gen(input logic [7:0] from);
    logic [7:0] l;
    int         k;
    bit         dup;
    l = from;
    k = 0;
    exp_ncyc = 0;
    while (k < 6 && exp_ncyc < 6 * 255) begin
      dup = 1'b0;
      for (int j = 0; j < k; j++) if (exp_act[j] == l[4:0]) dup = 1'b1;
      if (l[4:0] <= 5'd16 && !dup) begin
        exp_act[k] = l[4:0];
        k++;
      end
      exp_ncyc++;
      l = lfsr_next(l);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset(input string tag);
    start = 0; restart = 0; inp_valid = 0; undo = 0; inp_serial = 0;
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (show_valid !== 1'b0 || show_serial !== 5'd31) begin
      n_fail++;
      $display("FAIL %s show_rst: valid=%0b serial=%0d, required 0/31", tag, show_valid, show_serial);
    end
    n_tests++;
    if (input_count !== 3'd0 || inp_ready !== 1'b0 || inp_reject !== 1'b0 ||
        is_second_part_completed !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ctl_rst: count=%0d ready=%0b reject=%0b done=%0b, required 0/0/0/0", tag,
               input_count, inp_ready, inp_reject, is_second_part_completed);
    end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (act_w[i] !== 5'd31 || inp_w[i] !== 5'd31) begin
        n_fail++;
        $display("FAIL %s slot_rst[%0d]: act=%0d inp=%0d, required 31/31", tag, i, act_w[i], inp_w[i]);
      end
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) step();
    n_tests++;
    if (show_valid !== 1'b0 || inp_ready !== 1'b0 || input_count !== 3'd0) begin
      n_fail++;
      $display("FAIL %s idle_after: valid=%0b ready=%0b count=%0d, required 0/0/0", tag,
               show_valid, inp_ready, input_count);
    end
  endtask

  task automatic run_gen_show(input string tag);
    int errs;
    int bad_c;
    start = 1'b1;
    step();
    start = 1'b0;
    model_gen(m_lfsr);
    errs = 0;
    for (int j = 0; j < exp_ncyc; j++) begin
      if (show_valid !== 1'b0) errs++;
      step();
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL %s gen_latency: show_valid high %0d of %0d cycles, required 0", tag, errs,
               exp_ncyc);
    end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (act_w[i] !== exp_act[i]) begin
        n_fail++;
        $display("FAIL %s act[%0d]: got %0d, required %0d", tag, i, act_w[i], exp_act[i]);
      end
    end
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      if (act_w[i] > 5'd16) errs++;
      for (int j = i + 1; j < 6; j++) if (act_w[i] === act_w[j]) errs++;
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL %s act_distinct: %0d violations, required 0", tag, errs);
    end
    errs = 0;
    bad_c = -1;
    for (int c = 0; c < 6 * ShowCycles; c++) begin
      if (show_valid !== 1'b1 || show_serial !== exp_act[c / ShowCycles]) begin
        errs++;
        if (bad_c < 0) bad_c = c;
      end
      step();
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL %s show_seq: %0d bad cycles (first %0d), required 0", tag, errs, bad_c);
    end
    n_tests++;
    if (show_valid !== 1'b0 || show_serial !== 5'd31 || inp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s show_end: valid=%0b serial=%0d ready=%0b, required 0/31/1", tag,
               show_valid, show_serial, inp_ready);
    end
  endtask

  task automatic test_reject_undo();
    inp_valid = 1; inp_serial = 5'd5; step();
    inp_serial = 5'd6; step();
    inp_serial = 5'd20; step();
    inp_valid = 0;
    n_tests++;
    if (inp_reject !== 1'b1 || input_count !== 3'd2 || inp_w[2] !== 5'd31 ||
        inp_w[0] !== 5'd5 || inp_w[1] !== 5'd6) begin
      n_fail++;
      $display("FAIL reject: rej=%0b count=%0d slots=%0d,%0d,%0d, required 1/2 5,6,31",
               inp_reject, input_count, inp_w[0], inp_w[1], inp_w[2]);
    end
    step();
    n_tests++;
    if (inp_reject !== 1'b0 || input_count !== 3'd2) begin
      n_fail++;
      $display("FAIL reject_pulse: rej=%0b count=%0d, required 0/2", inp_reject, input_count);
    end
    undo = 1; step();
    n_tests++;
    if (input_count !== 3'd1 || inp_w[1] !== 5'd31 || inp_w[0] !== 5'd5) begin
      n_fail++;
      $display("FAIL undo1: count=%0d slots=%0d,%0d, required 1 5,31", input_count, inp_w[0],
               inp_w[1]);
    end
    inp_valid = 1; inp_serial = 5'd8; step();
    undo = 0; inp_valid = 0;
    n_tests++;
    if (input_count !== 3'd0 || inp_w[0] !== 5'd31 || inp_w[1] !== 5'd31) begin
      n_fail++;
      $display("FAIL undo_prio: count=%0d slots=%0d,%0d, required 0 31,31", input_count,
               inp_w[0], inp_w[1]);
    end
    undo = 1; step(); undo = 0;
    n_tests++;
    if (input_count !== 3'd0 || inp_w[0] !== 5'd31 || inp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL undo_empty: count=%0d slot0=%0d ready=%0b, required 0/31/1", input_count,
               inp_w[0], inp_ready);
    end
  endtask

  task automatic test_fill();
    fill_vals = '{5'd3, 5'd7, 5'd16, 5'd0, 5'd9, 5'd12};
    for (int i = 0; i < 6; i++) begin
      inp_valid = 1; inp_serial = fill_vals[i];
      step();
      n_tests++;
      if (input_count !== 3'(i + 1) || inp_w[i] !== fill_vals[i] ||
          is_second_part_completed !== (i == 5)) begin
        n_fail++;
        $display("FAIL fill[%0d]: count=%0d slot=%0d done=%0b, required %0d/%0d/%0b", i,
                 input_count, inp_w[i], is_second_part_completed, i + 1, fill_vals[i], i == 5);
      end
    end
    inp_valid = 0;
    n_tests++;
    if (inp_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_ready: got %0b, required 0", inp_ready);
    end
  endtask

  task automatic test_done_frozen();
    undo = 1; inp_valid = 1; inp_serial = 5'd1; start = 1;
    repeat (3) step();
    undo = 0; inp_valid = 0; start = 0;
    n_tests++;
    if (is_second_part_completed !== 1'b1 || input_count !== 3'd6 || inp_ready !== 1'b0 ||
        show_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_ctl: done=%0b count=%0d ready=%0b valid=%0b, required 1/6/0/0",
               is_second_part_completed, input_count, inp_ready, show_valid);
    end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (inp_w[i] !== fill_vals[i] || act_w[i] !== exp_act[i]) begin
        n_fail++;
        $display("FAIL done_frozen[%0d]: inp=%0d act=%0d, required %0d/%0d", i, inp_w[i],
                 act_w[i], fill_vals[i], exp_act[i]);
      end
    end
  endtask

  task automatic test_restart();
    int errs;
    restart = 1; step(); restart = 0;
    errs = 0;
    for (int i = 0; i < 6; i++) if (act_w[i] !== 5'd31 || inp_w[i] !== 5'd31) errs++;
    n_tests++;
    if (errs != 0 || input_count !== 3'd0 || is_second_part_completed !== 1'b0 ||
        inp_ready !== 1'b0 || show_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL restart: bad_slots=%0d count=%0d done=%0b ready=%0b, required 0/0/0/0", errs,
               input_count, is_second_part_completed, inp_ready);
    end
  endtask

  task automatic test_random_collect();
    logic [4:0] q[$];
    logic [4:0] s;
    int         errs, it;
    bit         v, u, exp_rej;
    errs = 0;
    it = 0;
    while (q.size() < 6 && it < 500) begin
      v = 1'($urandom_range(0, 1));
      u = ($urandom_range(0, 4) == 0);
      s = 5'($urandom_range(0, 20));
      inp_valid = v; undo = u; inp_serial = s;
      #1;
      if (inp_ready !== 1'b1) errs++;
      exp_rej = 1'b0;
      if (u) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if (v) begin
        if (s <= 5'd16) q.push_back(s);
        else exp_rej = 1'b1;
      end
      step();
      if (input_count !== 3'(q.size()) || inp_reject !== exp_rej) errs++;
      for (int i = 0; i < 6; i++) if (inp_w[i] !== ((i < q.size()) ? q[i] : 5'd31)) errs++;
      it++;
    end
    inp_valid = 0; undo = 0;
    n_tests++;
    if (errs != 0 || q.size() != 6) begin
      n_fail++;
      $display("FAIL random_collect: %0d errors, model count %0d after %0d cycles, required 0/6",
               errs, q.size(), it);
    end
    n_tests++;
    if (is_second_part_completed !== 1'b1 || inp_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL random_done: done=%0b ready=%0b, required 1/0", is_second_part_completed,
               inp_ready);
    end
  endtask

  task automatic test_reset_mid_show();
    start = 1; step(); start = 0;
    for (int w = 0; w < 2000 && show_valid !== 1'b1; w++) step();
    n_tests++;
    if (show_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_show_reach: show_valid=%0b, required 1", show_valid);
    end
    repeat (5) step();
    test_reset("mid_show");
  endtask

  task automatic test_reset_mid_collect();
    run_gen_show("r4");
    for (int i = 0; i < 3; i++) begin
      inp_valid = 1; inp_serial = 5'(i + 1); step();
    end
    inp_valid = 0;
    n_tests++;
    if (input_count !== 3'd3) begin
      n_fail++;
      $display("FAIL mid_collect_count: got %0d, required 3", input_count);
    end
    test_reset("mid_collect");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1; start = 0; restart = 0; inp_valid = 0; undo = 0; inp_serial = 0;
    test_reset("por");
    run_gen_show("r1");
    test_reject_undo();
    test_fill();
    test_done_frozen();
    test_restart();
    run_gen_show("r2");
    test_random_collect();
    test_restart();
    test_reset_mid_show();
    run_gen_show("r3");
    test_random_collect();
    test_restart();
    test_reset_mid_collect();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/captcha_sequence_recorder.md
# captcha_sequence_recorder

Producer side of the CAPTCHA result path. Generates six distinct expected serials (0–16), presents them one at a time for display, then records six user selections through a valid/ready handshake with undo. Drives the six `*_act` / `*_inp` buses and `is_second_part_completed` consumed by the result-analysis block.

## Interface
**Parameters**
- `MAX_ROUND`, 6: slots per sequence; fixed at 6 by the downstream port list.
- `SERIAL_MAX`, 16: largest legal serial.
- `IMPOSSIBLE_SERIAL`, 31: value held in an unfilled or cleared slot.
- `SHOW_CYCLES`, 100_000_000: clock cycles each expected serial is presented.
- `LFSR_SEED`, 8'hA5: LFSR value after reset (must be non-zero).

**Ports**
- `clock` in 1: system clock. One clock; reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; honoured only in IDLE.
- `restart` in 1: one-cycle pulse; honoured only in DONE.
- `inp_valid` in 1: user selection offered.
- `inp_serial` in 5: offered serial.
- `undo` in 1: one-cycle pulse; removes last recorded input.
- `inp_ready` out 1: high in COLLECT while count < 6.
- `inp_reject` out 1: one-cycle pulse when an offered serial > SERIAL_MAX.
- `show_valid` out 1: high in SHOW.
- `show_serial` out 5: expected serial being shown; IMPOSSIBLE_SERIAL otherwise.
- `input_count` out 3: recorded inputs, 0–6.
- `first_act`..`sixth_act` out 5 each: expected sequence.
- `first_inp`..`sixth_inp` out 5 each: recorded user sequence.
- `is_second_part_completed` out 1: high in DONE.

## Operation
- States: IDLE, GENERATE, SHOW, COLLECT, DONE. All registered outputs change only on `clock` rising edges (except async reset).
- Reset: state IDLE. All `*_act`/`*_inp`/`show_serial` = 31. `input_count`, `inp_ready`, `inp_reject`, `show_valid`, `is_second_part_completed` = 0. LFSR = LFSR_SEED.
- LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. Advances every cycle in every state. Candidate = `lfsr[4:0]`.
- IDLE: `start` moves to GENERATE, clears all slots to 31, and clears gen index k to 0.
- GENERATE: each cycle, accept the candidate if ≤ SERIAL_MAX and not equal to any of expected[0..k-1]. On accept, write expected[k] and increment k. Otherwise retry next cycle. When k reaches 6, go to SHOW with show index 0 and the dwell counter at 0.
- SHOW: `show_valid`=1 and `show_serial`=expected[idx]. After SHOW_CYCLES cycles, idx increments. After the 6th dwell, go to COLLECT with `show_serial`=31.
- COLLECT: a transfer occurs on a cycle where `inp_valid && inp_ready && !undo`:
  - If `inp_serial` ≤ 16: write slot[`input_count`] and increment the count.
  - Else: pulse `inp_reject` and write nothing.
  - Duplicate user serials are accepted; scoring is downstream.
- Undo in COLLECT: if count > 0, decrement the count and set that slot to 31. If count = 0, no effect. `undo` takes priority over a same-cycle `inp_valid`; the offered input is dropped, not held.
- Count reaching 6 moves to DONE on the same edge that writes the sixth slot. `inp_ready` is low in DONE.
- DONE: all buses frozen. `is_second_part_completed`=1. `undo` is ignored. `restart` moves to IDLE, clears all slots to 31, clears the count, and drops completed. `start` is ignored outside IDLE.
- Reset asserted mid-operation from any state returns immediately to the reset values.

## Timing
- `inp_ready` is combinational from state and count, valid the same cycle. The transfer is registered and the slot is visible the next cycle.
- GENERATE latency: at least 6 cycles. Every 5-bit value recurs within 255 cycles, so the bound is 6×255 cycles.
- SHOW duration: exactly 6×SHOW_CYCLES cycles from entering SHOW to the COLLECT transition.
- `is_second_part_completed` rises 1 cycle after the 6th accepted transfer. Downstream samples it at 100 Hz and needs it held, which DONE guarantees.
- `inp_reject` is high for exactly 1 cycle per rejected offer.

## Test plan
- Reset, then `start` with SHOW_CYCLES=4 → six acts, pairwise distinct, each ≤ 16, equal to the bench LFSR model. SHOW spans exactly 24 cycles; `show_serial` steps through acts in order.
- In COLLECT, offer 3,7,16,0,9,12 → `first_inp`..`sixth_inp` = 3,7,16,0,9,12. `input_count` goes 1..6. Completed rises on the cycle after the last transfer, and `inp_ready`=0.
- Offer 20 at count 2 → `inp_reject` pulses once, count stays 2, slot 2 stays 31.
- Offer 5,6, then `undo`, then `undo`+`inp_valid`(8) in the same cycle → count 0, slots 0–1 = 31. An extra `undo` at count 0 has no effect.
- In DONE, pulse `restart` → IDLE. All buses return to 31, completed drops, and a following `start` produces a fresh sequence.
- Assert `reset` mid-SHOW and mid-COLLECT (count 3) → all outputs take reset values asynchronously, and the state is IDLE after deassertion.
